// File: rtl/prbs7_frame_gen.sv
// PRBS7 (x^7+x^6+1) 64-bit frame generator for the serializer.
// Each start sends a clean training burst, then RUN words with optional
// user-byte insertion and error injection. Outputs are registered: a word
// generated in cycle t appears on dout/dout_valid in cycle t+1.
module prbs7_frame_gen #(
  parameter int unsigned TRAIN_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [6:0]  seed,
  input  logic [1:0]  user_mode,
  input  logic [7:0]  userData,
  input  logic [15:0] inj_period,
  input  logic [63:0] inj_mask,
  input  logic        inj_single,
  output logic [63:0] dout,
  output logic        dout_valid,
  output logic        training,
  output logic [15:0] injCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAIN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [16:0] TRAIN_LIM = 17'(TRAIN_WORDS);

  state_t      state_q, state_d;
  logic [6:0]  lfsr_q, lfsr_d, lfsr_adv, gen_s, seed_fix;
  logic [63:0] prbs_word, run_word, dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        training_q, training_d;
  logic        pend_q, pend_d, pend_eff, per_hit, inject;
  logic [15:0] train_cnt_q, train_cnt_d;
  logic [15:0] per_cnt_q, per_cnt_d;
  logic [15:0] inj_cnt_q, inj_cnt_d;
  logic [16:0] per_next, train_next;

  // An all-zero seed would lock the LFSR, so it is replaced by all ones.
  assign seed_fix = (seed == 7'd0) ? 7'h7F : seed;

  // 64 LFSR steps unrolled: bit i of the word is the i-th generated bit.
  always_comb begin
    gen_s     = lfsr_q;
    prbs_word = '0;
    for (int i = 0; i < 64; i++) begin
      prbs_word[i] = gen_s[6] ^ gen_s[5];
      gen_s        = {gen_s[5:0], prbs_word[i]};
    end
    lfsr_adv = gen_s;
  end

  // RUN word shaping (user byte after PRBS) and injection decision.
  always_comb begin
    run_word = prbs_word;
    case (user_mode)
      2'b01:   run_word[7:0]   = userData;
      2'b10:   run_word[63:56] = userData;
      2'b11:   run_word        = 64'hAAAA_AAAA_AAAA_AAAA;
      default: run_word        = prbs_word;
    endcase
    // A counter already at or past a newly written period fires on the next word.
    per_next = {1'b0, per_cnt_q} + 17'd1;
    per_hit  = (inj_period != 16'd0) && (per_next >= {1'b0, inj_period});
    pend_eff = pend_q | inj_single;
    inject   = per_hit | pend_eff;
  end

  // Next-state logic: load beats enable, enable low parks in IDLE.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    training_d   = 1'b0;
    pend_d       = pend_eff;
    train_cnt_d  = train_cnt_q;
    per_cnt_d    = per_cnt_q;
    inj_cnt_d    = inj_cnt_q;
    train_next   = {1'b0, train_cnt_q} + 17'd1;
    if (load) begin
      state_d   = S_IDLE;
      lfsr_d    = seed_fix;
      per_cnt_d = '0;
    end else if (!enable) begin
      state_d   = S_IDLE;
      per_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          lfsr_d       = lfsr_adv;
          dout_d       = prbs_word;
          dout_valid_d = 1'b1;
          training_d   = 1'b1;
          train_cnt_d  = 16'd1;
          state_d      = (TRAIN_LIM <= 17'd1) ? S_RUN : S_TRAIN;
        end
        S_TRAIN: begin
          lfsr_d       = lfsr_adv;
          dout_d       = prbs_word;
          dout_valid_d = 1'b1;
          training_d   = 1'b1;
          train_cnt_d  = train_next[15:0];
          state_d      = (train_next >= TRAIN_LIM) ? S_RUN : S_TRAIN;
        end
        S_RUN: begin
          lfsr_d       = lfsr_adv;
          dout_d       = run_word ^ (inject ? inj_mask : 64'd0);
          dout_valid_d = 1'b1;
          pend_d       = 1'b0;
          if (inj_period != 16'd0) begin
            per_cnt_d = per_hit ? 16'd0 : per_next[15:0];
          end
          if (inject && (inj_cnt_q != 16'hFFFF)) begin
            inj_cnt_d = inj_cnt_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= seed_fix;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      training_q   <= 1'b0;
      pend_q       <= 1'b0;
      train_cnt_q  <= '0;
      per_cnt_q    <= '0;
      inj_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      training_q   <= training_d;
      pend_q       <= pend_d;
      train_cnt_q  <= train_cnt_d;
      per_cnt_q    <= per_cnt_d;
      inj_cnt_q    <= inj_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign training   = training_q;
  assign injCount   = inj_cnt_q;

endmodule

// File: tb/tb_prbs7_frame_gen.sv
// Bench for prbs7_frame_gen: stream-level reference model (PRBS7 bit
// sequence b[n] = b[n-7]^b[n-6] indexed by position), constant-vector table,
// hand-written corner sequences and a randomized run.
module tb_prbs7_frame_gen;
  localparam int TW = 4;

  // clock / reset block
  logic        clk = 1'b0;
  logic        reset, enable, load, inj_single;
  logic [6:0]  seed;
  logic [1:0]  user_mode;
  logic [7:0]  userData;
  logic [15:0] inj_period;
  logic [63:0] inj_mask;
  logic [63:0] dout;
  logic        dout_valid, training;
  logic [15:0] injCount;

  always #5 clk = ~clk;

  prbs7_frame_gen #(.TRAIN_WORDS(TW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seed(seed),
    .user_mode(user_mode), .userData(userData), .inj_period(inj_period),
    .inj_mask(inj_mask), .inj_single(inj_single), .dout(dout),
    .dout_valid(dout_valid), .training(training), .injCount(injCount)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          seq[127];
  int          pos;
  bit          m_enabled;
  int          train_left;
  logic [63:0] exp_dout, m_pure;
  bit          exp_valid, exp_training, m_pend;
  int          exp_inj, m_pc;

  function automatic void build_seq(logic [6:0] sd);
    logic [6:0] s;
    bit h[134];
    s = (sd == 7'd0) ? 7'h7F : sd;
    for (int j = 0; j < 7; j++) h[j] = s[6-j];
    for (int n = 7; n < 134; n++) h[n] = h[n-7] ^ h[n-6];
    for (int n = 0; n < 127; n++) seq[n] = h[n+7];
  endfunction

  function automatic logic [63:0] next_prbs();
    logic [63:0] w;
    for (int i = 0; i < 64; i++) w[i] = seq[(pos + i) % 127];
    pos = (pos + 64) % 127;
    return w;
  endfunction

  function automatic void model_step();
    logic [63:0] w;
    bit pend_now, hit;
    if (reset) begin
      build_seq(seed);
      pos = 0; m_enabled = 0; train_left = 0;
      exp_dout = '0; exp_valid = 0; exp_training = 0;
      exp_inj = 0; m_pc = 0; m_pend = 0;
      return;
    end
    pend_now     = m_pend | inj_single;
    m_pend       = pend_now;
    exp_valid    = 0;
    exp_training = 0;
    if (load) begin
      build_seq(seed);
      pos = 0; m_enabled = 0; m_pc = 0;
    end else if (!enable) begin
      m_enabled = 0; m_pc = 0;
    end else begin
      if (!m_enabled) begin
        m_enabled  = 1;
        train_left = TW;
      end
      w         = next_prbs();
      m_pure    = w;
      exp_valid = 1;
      if (train_left > 0) begin
        train_left--;
        exp_training = 1;
        exp_dout     = w;
      end else begin
        if (user_mode == 2'b01) w[7:0] = userData;
        else if (user_mode == 2'b10) w[63:56] = userData;
        else if (user_mode == 2'b11) w = 64'hAAAA_AAAA_AAAA_AAAA;
        hit = 0;
        if (inj_period != 16'd0) begin
          m_pc++;
          if (m_pc >= int'(inj_period)) begin
            hit  = 1;
            m_pc = 0;
          end
        end
        if (hit || pend_now) begin
          w = w ^ inj_mask;
          if (exp_inj < 65535) exp_inj++;
        end
        m_pend   = 0;
        exp_dout = w;
      end
    end
  endfunction

  // scoreboard helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " dout"}, dout, exp_dout);
    chk({tag, " dout_valid"}, 64'(dout_valid), 64'(exp_valid));
    chk({tag, " training"}, 64'(training), 64'(exp_training));
    chk({tag, " injCount"}, 64'(injCount), 64'(exp_inj));
  endtask

  // driver: model sees the inputs present at the edge, outputs sampled on negedge
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset(input logic [6:0] sd);
    seed = sd; reset = 1'b1; enable = 1'b0; load = 1'b0; inj_single = 1'b0;
    inj_period = '0; inj_mask = '0; user_mode = 2'b00; userData = '0;
    tick("reset");
    tick("reset");
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  data;
    logic        single;
    logic [63:0] mask;
    logic [63:0] cmask;
    logic [63:0] cval;
  } vec_t;

  vec_t vecs[6];
  logic [63:0] words[$];

  initial begin
    vecs[0] = '{2'b01, 8'hA5, 1'b0, 64'h0, 64'hFF, 64'hA5};
    vecs[1] = '{2'b10, 8'h3C, 1'b0, 64'h0, 64'hFF00_0000_0000_0000, 64'h3C00_0000_0000_0000};
    vecs[2] = '{2'b11, 8'h00, 1'b0, 64'h0, '1, 64'hAAAA_AAAA_AAAA_AAAA};
    vecs[3] = '{2'b11, 8'h00, 1'b1, 64'hF, '1, 64'hAAAA_AAAA_AAAA_AAA5};
    vecs[4] = '{2'b01, 8'h00, 1'b0, 64'h0, 64'hFF, 64'h00};
    vecs[5] = '{2'b10, 8'hFF, 1'b1, 64'h8000_0000_0000_0000,
                64'hFF00_0000_0000_0000, 64'h7F00_0000_0000_0000};

    // reset state
    do_reset(7'h7F);
    chk("reset dout", dout, 64'd0);
    chk("reset valid", 64'(dout_valid), 64'd0);
    chk("reset training", 64'(training), 64'd0);
    chk("reset injCount", 64'(injCount), 64'd0);

    // first word, training burst, user byte only after training
    user_mode = 2'b01; userData = 8'hA5; enable = 1'b1;
    tick("first");
    chk("first byte0", 64'(dout[7:0]), 64'h40);
    chk("first training", 64'(training), 64'd1);
    chk("first valid", 64'(dout_valid), 64'd1);
    for (int i = 1; i < TW; i++) begin
      tick("train");
      chk("train flag", 64'(training), 64'd1);
    end
    tick("run0");
    chk("run0 training", 64'(training), 64'd0);
    chk("run0 byte0", 64'(dout[7:0]), 64'hA5);

    // constant vector table in RUN
    for (int i = 0; i < 6; i++) begin
      user_mode = vecs[i].mode; userData = vecs[i].data;
      inj_single = vecs[i].single; inj_mask = vecs[i].mask;
      tick("vec");
      chk($sformatf("vec%0d", i), dout & vecs[i].cmask, vecs[i].cval);
      inj_single = 1'b0;
    end
    chk("vec injCount", 64'(injCount), 64'd2);

    // PRBS7 period with 64-bit words
    user_mode = 2'b00; inj_mask = '0;
    words.delete();
    for (int i = 0; i < 130; i++) begin
      tick("period");
      words.push_back(dout);
    end
    for (int k = 0; k < 3; k++) chk($sformatf("period k%0d", k), words[k+127], words[k]);

    // periodic injection every 3rd RUN word
    do_reset(7'h55);
    enable = 1'b1; inj_period = 16'd3; inj_mask = 64'h1;
    for (int i = 0; i < TW; i++) tick("inj train");
    for (int k = 1; k <= 30; k++) begin
      tick("inj");
      chk($sformatf("inj diff w%0d", k), dout ^ m_pure, (k % 3 == 0) ? 64'h1 : 64'h0);
    end
    chk("inj count30", 64'(injCount), 64'd10);

    // single pulse coinciding with the periodic hit
    tick("inj31");
    tick("inj32");
    inj_single = 1'b1;
    tick("inj33");
    inj_single = 1'b0;
    chk("both diff", dout ^ m_pure, 64'h1);
    chk("both count", 64'(injCount), 64'd11);

    // load mid-RUN, restart from new seed
    seed = 7'h7F; load = 1'b1;
    tick("load");
    load = 1'b0;
    chk("load valid", 64'(dout_valid), 64'd0);
    tick("reload");
    chk("reload byte0", 64'(dout[7:0]), 64'h40);
    chk("reload training", 64'(training), 64'd1);
    for (int i = 0; i < 5; i++) tick("reload run");

    // enable low mid-RUN then resume without a sequence gap
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick("pause");
      chk("pause valid", 64'(dout_valid), 64'd0);
    end
    enable = 1'b1;
    tick("resume");
    chk("resume training", 64'(training), 64'd1);
    for (int i = 0; i < 6; i++) tick("resume run");

    // zero seed behaves like all ones, via reset and via load
    do_reset(7'h00);
    enable = 1'b1;
    tick("seed0");
    chk("seed0 byte0", 64'(dout[7:0]), 64'h40);
    for (int i = 0; i < 8; i++) tick("seed0 run");
    seed = 7'h00; load = 1'b1;
    tick("load0");
    load = 1'b0;
    tick("load0 first");
    chk("load0 byte0", 64'(dout[7:0]), 64'h40);

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      enable     = ($urandom_range(0, 15) != 0);
      load       = ($urandom_range(0, 40) == 0);
      seed       = 7'($urandom_range(0, 127));
      user_mode  = 2'($urandom_range(0, 3));
      userData   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 20) == 0) inj_period = 16'($urandom_range(0, 5));
      inj_mask   = {$urandom, $urandom};
      inj_single = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
